// File: rtl/printer_cmd_regbank.sv
// rtl/printer_cmd_regbank.sv - Avalon-MM register bank with move-command queue, axis settings, flags and temperatures
module printer_cmd_regbank #(
  parameter int N_AXES = 5,
  parameter int DEPTH  = 8,
  parameter int N_TEMP = 3,
  parameter int TEMP_W = 12,
  parameter int ADDR_W = 6
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [ADDR_W-1:0]          avs_address,
  input  logic                       avs_write,
  input  logic [31:0]                avs_writedata,
  input  logic                       avs_read,
  output logic [31:0]                avs_readdata,
  output logic                       cmd_valid,
  input  logic                       cmd_ready,
  output logic [32*(N_AXES+4)-1:0]   cmd_data,
  output logic [32*3*N_AXES-1:0]     settings_out,
  input  logic [31:0]                flags_in,
  output logic [31:0]                flags_out,
  input  logic [TEMP_W*N_TEMP-1:0]   temp_in
);

  localparam int EW = 32 * (N_AXES + 4);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [31:0]       cmd_type, cmd_f, cmd_t, cmd_dt;
  logic [31:0]       cmd_axis  [N_AXES];
  logic [31:0]       max_speed [N_AXES];
  logic [31:0]       accel     [N_AXES];
  logic [31:0]       jerk      [N_AXES];
  logic [31:0]       flags_sticky;
  logic [TEMP_W-1:0] temp_q    [N_TEMP];

  logic [EW-1:0]     q_mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic              overflow;

  logic [31:0]       addr;
  logic [EW-1:0]     stage_vec;
  logic [31:0]       rdata;
  logic              ctrl_wr, commit, flush, clr_ovf, push, pop, full, empty;

  assign addr    = 32'(avs_address);
  assign ctrl_wr = avs_write && (addr == 32'h00);
  assign commit  = ctrl_wr && avs_writedata[0];
  assign flush   = ctrl_wr && avs_writedata[1];
  assign clr_ovf = ctrl_wr && avs_writedata[2];
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign pop     = cmd_valid && cmd_ready;
  assign push    = commit && (!full || pop);

  assign cmd_valid = !empty;
  assign cmd_data  = q_mem[rd_ptr];

  // Snapshot layout matches cmd_data: {dt, t, f, axis[N_AXES-1..0], type}
  always_comb begin
    stage_vec = '0;
    stage_vec[31:0] = cmd_type;
    for (int i = 0; i < N_AXES; i++) stage_vec[32*(i+1) +: 32] = cmd_axis[i];
    stage_vec[32*(N_AXES+1) +: 32] = cmd_f;
    stage_vec[32*(N_AXES+2) +: 32] = cmd_t;
    stage_vec[32*(N_AXES+3) +: 32] = cmd_dt;
  end

  always_comb begin
    for (int i = 0; i < N_AXES; i++) begin
      settings_out[32*i +: 32]            = max_speed[i];
      settings_out[32*(N_AXES+i) +: 32]   = accel[i];
      settings_out[32*(2*N_AXES+i) +: 32] = jerk[i];
    end
  end

  always_comb begin
    rdata = '0;
    if (addr == 32'h00) rdata = {16'h0, 8'(count), 5'h0, overflow, full, empty};
    if (addr == 32'h01) rdata = flags_sticky;
    if (addr == 32'h02) rdata = flags_out;
    if (addr == 32'h03) rdata = cmd_type;
    if (addr == 32'h0C) rdata = cmd_f;
    if (addr == 32'h0D) rdata = cmd_t;
    if (addr == 32'h0E) rdata = cmd_dt;
    for (int i = 0; i < N_AXES; i++) begin
      if (addr == 32'(4 + i))    rdata = cmd_axis[i];
      if (addr == 32'(32 + i))   rdata = max_speed[i];
      if (addr == 32'(40 + i))   rdata = accel[i];
      if (addr == 32'(48 + i))   rdata = jerk[i];
    end
    for (int c = 0; c < N_TEMP; c++)
      if (addr == 32'(16 + c)) rdata = 32'(temp_q[c]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_type     <= '0;
      cmd_f        <= '0;
      cmd_t        <= '0;
      cmd_dt       <= '0;
      flags_out    <= '0;
      flags_sticky <= '0;
      avs_readdata <= '0;
      for (int i = 0; i < N_AXES; i++) begin
        cmd_axis[i]  <= '0;
        max_speed[i] <= '0;
        accel[i]     <= '0;
        jerk[i]      <= '0;
      end
      for (int c = 0; c < N_TEMP; c++) temp_q[c] <= '0;
    end else begin
      if (avs_write) begin
        if (addr == 32'h02) flags_out <= avs_writedata;
        if (addr == 32'h03) cmd_type  <= avs_writedata;
        if (addr == 32'h0C) cmd_f     <= avs_writedata;
        if (addr == 32'h0D) cmd_t     <= avs_writedata;
        if (addr == 32'h0E) cmd_dt    <= avs_writedata;
        for (int i = 0; i < N_AXES; i++) begin
          if (addr == 32'(4 + i))  cmd_axis[i]  <= avs_writedata;
          if (addr == 32'(32 + i)) max_speed[i] <= avs_writedata;
          if (addr == 32'(40 + i)) accel[i]     <= avs_writedata;
          if (addr == 32'(48 + i)) jerk[i]      <= avs_writedata;
        end
      end
      // Incoming flags are OR'd after the W1C mask so a live flag survives its own clear
      if (avs_write && addr == 32'h01)
        flags_sticky <= (flags_sticky & ~avs_writedata) | flags_in;
      else
        flags_sticky <= flags_sticky | flags_in;
      for (int c = 0; c < N_TEMP; c++) temp_q[c] <= temp_in[TEMP_W*c +: TEMP_W];
      if (avs_read) avs_readdata <= rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)      count <= count + 1'b1;
        else if (pop && !push) count <= count - 1'b1;
      end
      if (commit && full && !pop && !flush) overflow <= 1'b1;
      else if (clr_ovf)                     overflow <= 1'b0;
    end
  end

  // Entry storage carries no reset so it can map onto RAM; validity comes from count
  always_ff @(posedge clk) begin
    if (push && !flush) q_mem[wr_ptr] <= stage_vec;
  end

endmodule
